// File: rtl/window_collector_pkg.sv
// Shared FSM state type for the window collector.
package window_collector_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/window_collector.sv
// Collects INPUTS_NUM samples into a packed window for a downstream adder
// tree. A window closes when full or on flush, and is presented until
// taken. m_count carries the number of real samples for averaging.
module window_collector
  import window_collector_pkg::*;
#(
  parameter int INPUTS_NUM  = 125,
  parameter int IDATA_WIDTH = 16,
  parameter int CNT_WIDTH   = $clog2(INPUTS_NUM + 1)
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [IDATA_WIDTH-1:0]                 s_data,
  input  logic                                   flush,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]                   m_count
);

  state_e                                 state_q;
  logic                                   s_ready_q;
  logic                                   m_valid_q;
  logic [CNT_WIDTH-1:0]                   cnt_q;
  logic [CNT_WIDTH-1:0]                   cnt_d;
  logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] slots_q;

  logic accept;
  logic last_slot;
  logic close_win;
  logic release_win;

  // s_ready_q mirrors state FILL, so acceptance never depends on m_ready.
  assign accept      = s_valid && s_ready_q;
  assign last_slot   = (cnt_q == CNT_WIDTH'(INPUTS_NUM - 1));
  // A flush closes the window only if it holds at least one sample,
  // counting a sample accepted in the same cycle.
  assign close_win   = s_ready_q &&
                       ((accept && last_slot) ||
                        (flush && (accept || (cnt_q != '0))));
  assign release_win = m_valid_q && m_ready;

  // Next fill count: cleared on release, advanced on each accepted sample.
  always_comb begin
    cnt_d = cnt_q;
    if (release_win) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Two-state control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= FILL;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (close_win) begin
            state_q   <= FULL;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (m_ready) begin
            state_q   <= FILL;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= FILL;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Fill counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sample buffer: write the accepted sample into slot cnt, wipe on release
  // so that unwritten slots of a flushed window read as zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slots_q <= '0;
    end else if (release_win) begin
      slots_q <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < INPUTS_NUM; i++) begin
        if (cnt_q == CNT_WIDTH'(i)) begin
          slots_q[i] <= s_data;
        end
      end
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = slots_q;
  assign m_count = cnt_q;

endmodule
